// File: rtl/badapple_pkg.sv
// Shared constants and channel identifiers for the bitstream demux slice.
package badapple_pkg;
  localparam int DEF_WORD_W     = 8;
  localparam int DEF_FIFO_DEPTH = 16;

  typedef enum logic [0:0] {
    CH_VIDEO = 1'b0,
    CH_AUDIO = 1'b1
  } ch_id_e;
endpackage

// File: rtl/bitstream_demux_if.sv
// Per-channel word output bus: FWFT head, valid/ready and occupancy.
interface bitstream_demux_if #(
  parameter int NUM_CH     = 2,
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 16
) ();
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [NUM_CH*WORD_W-1:0] out_data;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*LW-1:0]     fifo_level;

  modport master (output out_data, output out_valid, output fifo_level, input  out_ready);
  modport slave  (input  out_data, input  out_valid, input  fifo_level, output out_ready);
endinterface

// File: rtl/stream_fifo.sv
// Single-clock first-word-fall-through FIFO; full/empty come from the level counter.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/bitstream_demux.sv
// Serial bit deserialiser: packs accepted bits per selected channel into words,
// queues them in per-channel FIFOs, and keeps a freezable capture of recent bits.
module bitstream_demux
  import badapple_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int DEBUG_W    = 24
) (
  input  logic               CLK_40,
  input  logic               reset,
  input  logic               bit_en,
  input  logic               bit_in,
  input  logic [NUM_CH-1:0]  ch_sel,
  input  logic               frame_flush,
  input  logic               clear_err,
  bitstream_demux_if.master  ob,
  output logic [NUM_CH-1:0]  overflow,
  output logic               sel_err,
  input  logic               dbg_freeze,
  output logic [DEBUG_W-1:0] dbg_word
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(WORD_W);

  logic multi_sel, one_hot, accept;
  logic [NUM_CH-1:0]             pk_push, f_full, f_empty, pop, drop;
  logic [NUM_CH-1:0][WORD_W-1:0] pk_next, head_a;
  logic [NUM_CH-1:0][LW-1:0]     level_a;

  assign multi_sel = |(ch_sel & (ch_sel - NUM_CH'(1)));
  assign one_hot   = (|ch_sel) & ~multi_sel;
  // Flush wins over a coincident strobe, so the bit is simply not accepted.
  assign accept    = bit_en & one_hot & ~frame_flush;

  assign ob.out_data   = head_a;
  assign ob.fifo_level = level_a;
  assign ob.out_valid  = ~f_empty;
  assign pop           = ~f_empty & ob.out_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WORD_W-1:0] sr;
    logic [CW-1:0]     cnt;
    logic              take;

    assign take = accept & ch_sel[c];

    if (MSB_FIRST) begin : g_msb
      assign pk_next[c] = {sr[WORD_W-2:0], bit_in};
    end else begin : g_lsb
      assign pk_next[c] = {bit_in, sr[WORD_W-1:1]};
    end

    assign pk_push[c] = take & (cnt == CW'(WORD_W - 1));
    // A full FIFO drops the word, but the packer still wraps to stay word-aligned.
    assign drop[c]    = pk_push[c] & f_full[c] & ~pop[c];

    always_ff @(posedge CLK_40) begin
      if (reset || frame_flush) begin
        sr  <= '0;
        cnt <= '0;
      end else if (take) begin
        sr  <= pk_next[c];
        cnt <= pk_push[c] ? '0 : cnt + 1'b1;
      end
    end

    stream_fifo #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
      .clk       (CLK_40),
      .rst       (reset),
      .push      (pk_push[c]),
      .push_data (pk_next[c]),
      .pop       (pop[c]),
      .head      (head_a[c]),
      .level     (level_a[c]),
      .full      (f_full[c]),
      .empty     (f_empty[c])
    );
  end

  // Error flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      overflow <= '0;
      sel_err  <= 1'b0;
    end else begin
      overflow <= (clear_err ? '0 : overflow) | drop;
      sel_err  <= (clear_err ? 1'b0 : sel_err) | (bit_en & multi_sel);
    end
  end

  always_ff @(posedge CLK_40) begin
    if (reset)                    dbg_word <= '0;
    else if (accept && !dbg_freeze) dbg_word <= {dbg_word[DEBUG_W-2:0], bit_in};
  end
endmodule

// File: tb/tb_bitstream_demux.sv
// Scoreboard bench: expected words queued as bits are driven, compared on pop.
module tb_bitstream_demux;
  logic       clk = 1'b0;
  logic       reset, bit_en, bit_in, frame_flush, clear_err, dbg_freeze;
  logic [1:0] ch_sel, rdy_a;
  logic [1:0] ovf_a, ovf_b;
  logic       serr_a, serr_b;
  logic [23:0] dbg_a, dbg_b;

  int n_chk = 0, n_pass = 0;
  logic [7:0] q0[$], q1[$];

  always #5 clk = ~clk;

  bitstream_demux_if #(.NUM_CH(2), .WORD_W(8), .FIFO_DEPTH(16)) ifa ();
  bitstream_demux_if #(.NUM_CH(2), .WORD_W(8), .FIFO_DEPTH(16)) ifb ();
  assign ifa.out_ready = rdy_a;
  assign ifb.out_ready = 2'b00;

  bitstream_demux #(.MSB_FIRST(1'b1)) dut_a (
    .CLK_40(clk), .reset(reset), .bit_en(bit_en), .bit_in(bit_in), .ch_sel(ch_sel),
    .frame_flush(frame_flush), .clear_err(clear_err), .ob(ifa), .overflow(ovf_a),
    .sel_err(serr_a), .dbg_freeze(dbg_freeze), .dbg_word(dbg_a)
  );

  bitstream_demux #(.MSB_FIRST(1'b0)) dut_b (
    .CLK_40(clk), .reset(reset), .bit_en(bit_en), .bit_in(bit_in), .ch_sel(ch_sel),
    .frame_flush(frame_flush), .clear_err(clear_err), .ob(ifb), .overflow(ovf_b),
    .sel_err(serr_b), .dbg_freeze(dbg_freeze), .dbg_word(dbg_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic [1:0] sel, input logic b);
    ch_sel = sel; bit_in = b; bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
  endtask

  task automatic send_word(input logic [1:0] sel, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(sel, w[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic drain(input int ch);
    logic [7:0] exp;
    for (int i = 0; i < 40; i++) begin
      if (!ifa.out_valid[ch]) break;
      if ((ch == 0 ? q0.size() : q1.size()) == 0) begin
        chk($sformatf("extra_word_ch%0d", ch), 1, 0);
        break;
      end
      exp = (ch == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("data_ch%0d", ch), ifa.out_data[ch*8 +: 8], exp);
      rdy_a[ch] = 1'b1; tick(); rdy_a[ch] = 1'b0;
    end
    chk($sformatf("q_left_ch%0d", ch), (ch == 0) ? q0.size() : q1.size(), 0);
    chk($sformatf("valid_drained_ch%0d", ch), ifa.out_valid[ch], 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, ifa.out_valid, 0);
    chk({tag, "_data"},  ifa.out_data, 0);
    chk({tag, "_level"}, ifa.fifo_level, 0);
    chk({tag, "_ovf"},   ovf_a, 0);
    chk({tag, "_serr"},  serr_a, 0);
    chk({tag, "_dbg"},   dbg_a, 0);
  endtask

  initial begin
    logic [7:0] w;
    reset = 1'b1; bit_en = 0; bit_in = 0; ch_sel = 0; frame_flush = 0;
    clear_err = 0; dbg_freeze = 0; rdy_a = 0;
    tick(); tick();
    reset = 1'b0;
    check_all_zero("reset");

    // Basic word on video: 1,0,1,0,0,1,1,0
    w = 8'hA6;
    for (int i = 7; i >= 1; i--) send_bit(2'b01, w[i]);
    chk("valid_before_last", ifa.out_valid[0], 0);
    send_bit(2'b01, w[0]);
    q0.push_back(8'hA6);
    chk("valid_after_last", ifa.out_valid[0], 1);
    chk("ch1_untouched_v", ifa.out_valid[1], 0);
    chk("ch1_untouched_l", ifa.fifo_level[9:5], 0);
    chk("dbg_a6", dbg_a, 24'h0000A6);
    drain(0);

    // Interleave: 1111 -> ch0, 3C -> ch1, 0000 -> ch0
    for (int i = 0; i < 4; i++) send_bit(2'b01, 1'b1);
    send_word(2'b10, 8'h3C); q1.push_back(8'h3C);
    for (int i = 0; i < 4; i++) send_bit(2'b01, 1'b0);
    q0.push_back(8'hF0);
    chk("dbg_interleave", dbg_a, 24'hA6F3C0);
    drain(1);
    drain(0);

    // Overflow: 17 words into a 16-deep FIFO with no consumer
    for (int i = 1; i <= 17; i++) begin
      send_word(2'b01, 8'(i));
      if (i <= 16) q0.push_back(8'(i));
    end
    chk("level_full", ifa.fifo_level[4:0], 16);
    chk("ovf_set", ovf_a, 2'b01);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("ovf_cleared", ovf_a, 0);
    // Push and pop in the same cycle while full
    w = 8'h99;
    for (int i = 7; i >= 1; i--) send_bit(2'b01, w[i]);
    chk("head_before_pp", ifa.out_data[7:0], q0[0]);
    rdy_a[0] = 1'b1;
    send_bit(2'b01, w[0]);
    rdy_a[0] = 1'b0;
    void'(q0.pop_front());
    q0.push_back(8'h99);
    chk("level_pushpop", ifa.fifo_level[4:0], 16);
    chk("ovf_pushpop", ovf_a, 0);
    drain(0);

    // Flush mid-word, with a coincident strobe
    send_bit(2'b01, 1); send_bit(2'b01, 0); send_bit(2'b01, 1);
    send_bit(2'b01, 1); send_bit(2'b01, 1);
    frame_flush = 1'b1; send_bit(2'b01, 1'b1); frame_flush = 1'b0;
    send_word(2'b01, 8'h81); q0.push_back(8'h81);
    chk("flush_level", ifa.fifo_level[4:0], 1);
    drain(0);

    // Select errors
    send_bit(2'b11, 1'b1);
    chk("serr_set", serr_a, 1);
    chk("serr_no_level", ifa.fifo_level, 0);
    send_bit(2'b00, 1'b1);
    chk("sel_none_level", ifa.fifo_level, 0);
    clear_err = 1'b1; tick(); clear_err = 1'b0;
    chk("serr_cleared", serr_a, 0);
    clear_err = 1'b1; send_bit(2'b11, 1'b0); clear_err = 1'b0;
    chk("serr_set_wins", serr_a, 1);

    // Reset mid-word and mid-FIFO
    send_word(2'b10, 8'h11);
    send_bit(2'b10, 1); send_bit(2'b10, 1); send_bit(2'b10, 1);
    do_reset();
    check_all_zero("midreset");
    send_word(2'b10, 8'h5A); q1.push_back(8'h5A);
    drain(1);

    // Debug freeze across 10 bits, then resume
    chk("dbg_5a", dbg_a, 24'h00005A);
    dbg_freeze = 1'b1;
    send_word(2'b01, 8'hFF); q0.push_back(8'hFF);
    send_bit(2'b01, 1); send_bit(2'b01, 0);
    chk("dbg_frozen", dbg_a, 24'h00005A);
    dbg_freeze = 1'b0;
    send_bit(2'b01, 1); send_bit(2'b01, 0); send_bit(2'b01, 0);
    send_bit(2'b01, 0); send_bit(2'b01, 0); send_bit(2'b01, 1);
    q0.push_back(8'hA1);
    chk("dbg_resume", dbg_a, 24'h0016A1);
    drain(0);

    // LSB-first instance sees the same stream
    do_reset();
    send_word(2'b01, 8'h80); q0.push_back(8'h80);
    chk("lsbf_valid", ifb.out_valid[0], 1);
    chk("lsbf_word", ifb.out_data[7:0], 8'h01);
    drain(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bitstream_demux.md
# bitstream_demux

Parametrised bit-stream deserialiser and channel router sitting between `DATA_FSM` and the video/audio consumers. On each qualified data-clock strobe it takes `received_bit` and packs it into a WORD_W-bit word for whichever channel is currently selected (video, audio, …). Completed words are pushed into a per-channel FIFO with a valid/ready output. It also exposes a freezable DEBUG_W-bit capture of the most recent accepted bits, which replaces the ad-hoc hex-display shift buffer.

## Interface
- NUM_CH, 2: number of output channels (ch 0 = video, ch 1 = audio).
- WORD_W, 8: bits per packed word.
- FIFO_DEPTH, 16: words per channel FIFO; power of two, ≥2.
- MSB_FIRST, 1: 1 means the first received bit lands in bit WORD_W-1; 0 means it lands in bit 0.
- DEBUG_W, 24: width of the debug capture register.
- CLK_40  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- bit_en  in  1  one-cycle strobe marking bit_in valid (data_clk_rising_edge).
- bit_in  in  1  serial data bit (received_bit).
- ch_sel  in  NUM_CH  channel-ready flags, expected one-hot (video_data_ready, audio_data_ready).
- frame_flush  in  1  discards all partial words (pulse on start_req).
- clear_err  in  1  clears the sticky error flags.
- out_data  out  NUM_CH*WORD_W  FIFO head words; channel c occupies [c*WORD_W +: WORD_W].
- out_valid  out  NUM_CH  FIFO non-empty, one bit per channel.
- out_ready  in  NUM_CH  consumer pop, one bit per channel.
- fifo_level  out  NUM_CH*$clog2(FIFO_DEPTH+1)  per-channel occupancy.
- overflow  out  NUM_CH  sticky: a completed word was dropped because the FIFO was full.
- sel_err  out  1  sticky: bit_en arrived with more than one ch_sel bit set.
- dbg_freeze  in  1  holds dbg_word while high.
- dbg_word  out  DEBUG_W  most recent accepted bits; the newest bit is in bit 0.

## Operation
- A bit is accepted when bit_en=1, ch_sel is exactly one-hot, and frame_flush=0.
- If bit_en=1 and ch_sel=0: the bit is ignored silently.
- If bit_en=1 and ch_sel has two or more bits set: the bit is ignored and sel_err is set.
- Per-channel packer: a shift register plus a bit counter running 0..WORD_W-1.
  - MSB_FIRST=1: shift left, inserting bit_in at the LSB.
  - MSB_FIRST=0: shift right, inserting bit_in at the MSB.
  - Counter at WORD_W-1 when a bit is accepted: the full word is pushed and the counter wraps to 0.
- Packers of non-selected channels hold their partial words, so interleaved channels resume correctly.
- FIFO push succeeds when level<FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the word is dropped, overflow[c] is set, and the packer still wraps.
- Pop occurs when out_valid[c]&&out_ready[c]. out_data is first-word-fall-through, showing the head while valid.
- frame_flush clears every packer counter and partial word. FIFO contents and error flags are preserved.
- frame_flush wins over a coincident bit_en: the bit is discarded.
- clear_err clears overflow and sel_err. If an error event occurs in the same cycle, the set wins.
- Debug register: every accepted bit shifts into dbg_word bit 0, independent of channel, unless dbg_freeze=1.

## Timing
- Reset values:
  - out_valid=0, out_data=0, fifo_level=0, overflow=0, sel_err=0, dbg_word=0.
  - All packer counters and shift registers are 0, and the FIFO pointers are 0.
- Latency:
  - Final bit accepted at cycle N: the word is in the FIFO at the edge ending cycle N, and out_valid[c]=1 in cycle N+1 if the FIFO was empty.
  - Pop at cycle N: the next head appears in cycle N+1, and out_valid drops in N+1 if the level reaches 0.
- fifo_level updates on the same edge as the push or pop. Simultaneous push and pop leaves the level unchanged.
- Wrap-around: FIFO read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full/empty are decided by the level counter.
- Reset asserted mid-word or mid-FIFO: all state returns to reset values on the next edge, and partial data is lost.
- bit_en is sampled only in the cycles where it is high. Back-to-back bit_en (every cycle) must be sustained.

## Structure
- Shared package `badapple_pkg`: default WORD_W and FIFO_DEPTH constants, plus the `ch_id_e` enum (CH_VIDEO=0, CH_AUDIO=1).
- One sub-module `stream_fifo` (parameters WIDTH, DEPTH): a single-clock FWFT FIFO with push, pop, level, full and empty. It is instantiated NUM_CH times in a generate loop.
- Packers and the debug register are inline in `bitstream_demux`.

## Test plan
- Defaults, ch_sel=01, eight bit_en pulses carrying 1,0,1,0,0,1,1,0: out_data[7:0]=8'hA6 with out_valid[0]=1 one cycle after the 8th bit; ch 1 is untouched.
- Interleave: 4 bits to ch 0 (1111), then 8 bits to ch 1 (8'h3C), then 4 bits to ch 0 (0000): ch 1 word is 8'h3C and ch 0 word is 8'hF0.
- out_ready=0, push 17 words on ch 0: fifo_level=16 and overflow[0]=1; popping 16 words returns words 1..16 in order.
- After 5 bits, pulse frame_flush together with a bit_en, then send 8 bits of 8'h81: a single word 8'h81 is produced.
- ch_sel=11 with bit_en: sel_err=1 and no level change. clear_err then returns it to 0; reset mid-word gives all outputs 0.
- MSB_FIRST=0, bits 1,0,0,0,0,0,0,0: word 8'h01. Also: dbg_freeze=1 holds dbg_word while 10 further bits arrive.
